approx_log_divider: RTL and testbench

- Signed 8-bit approximate divider using Mitchell logarithms. It is the inverse of the team's approximate log multiplier: log subtraction replaces log addition.
- Computes A/B as a signed Q8.8 quotient: absolute value, leading-one detection, log conversion, log subtraction, antilog shift, then sign set.
- Multi-cycle FSM with valid/ready handshakes on input and output. Sits beside the multiplier in the arithmetic datapath test harness.

---
 rtl/approx_log_divider.sv | 144 ++++++++++++++
 tb/tb_approx_log_divider.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/approx_log_divider.sv
// Signed 8-bit Mitchell-logarithm divider producing a Q8.8 quotient.
// Four-step pipeline walk (convert, subtract, antilog, present) behind valid/ready handshakes.
`timescale 1ns/1ps

module approx_log_divider #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] Q,
    output logic        dbz,
    output logic        sat
);

    typedef enum logic [2:0] {IDLE, CONV, SUB, ANTI, DONE} state_t;

    state_t state, state_next;

    logic [7:0]  a_r, b_r;
    logic [9:0]  log_a, log_b;
    logic        za, zb, sign_r;
    logic [10:0] d_r;

    logic [7:0]  a_abs, b_abs;
    logic [4:0]  s;
    logic [4:0]  rsh;
    logic [7:0]  m;
    logic [16:0] mag, mag_neg;
    logic [15:0] q_calc;
    logic        dbz_calc, sat_calc;

    // Log of an unsigned value: integer part is the leading-one position,
    // fraction is the bits below it left-justified into 7 bits.
    function automatic logic [9:0] mitchell_log(input logic [7:0] v);
        logic [2:0] k;
        logic [7:0] norm;
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) k = 3'(i);
        end
        norm = v << (3'd7 - k);
        return {k, norm[6:0]};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CONV;
            CONV:    state_next = SUB;
            SUB:     state_next = ANTI;
            ANTI:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // |-128| wraps to 0x80, which reads correctly as unsigned 128.
    assign a_abs = a_r[7] ? 8'(~a_r + 8'd1) : a_r;
    assign b_abs = b_r[7] ? 8'(~b_r + 8'd1) : b_r;

    always_comb begin
        s        = {d_r[10], d_r[10:7]} + 5'd1;
        m        = {1'b1, d_r[6:0]};
        rsh      = 5'd0;
        mag      = {9'd0, m} << s[3:0];
        if (s[4]) begin
            rsh = ~s + 5'd1;
            mag = {9'd0, m} >> rsh[2:0];
        end
        mag_neg  = ~mag + 17'd1;
        q_calc   = mag[15:0];
        dbz_calc = 1'b0;
        sat_calc = 1'b0;
        if (zb) begin
            dbz_calc = 1'b1;
            if (za)          q_calc = 16'h0000;
            else if (sign_r) q_calc = 16'h8000;
            else             q_calc = 16'h7FFF;
        end else if (za) begin
            q_calc = 16'h0000;
        end else if (sign_r) begin
            q_calc = mag_neg[15:0];
        end else if (mag > 17'd32767) begin
            sat_calc = 1'b1;
            q_calc   = SAT_EN ? 16'h7FFF : mag[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            log_a  <= '0;
            log_b  <= '0;
            za     <= 1'b0;
            zb     <= 1'b0;
            sign_r <= 1'b0;
            d_r    <= '0;
            Q      <= '0;
            dbz    <= 1'b0;
            sat    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= A;
                        b_r <= B;
                    end
                end
                CONV: begin
                    log_a  <= mitchell_log(a_abs);
                    log_b  <= mitchell_log(b_abs);
                    za     <= (a_r == 8'd0);
                    zb     <= (b_r == 8'd0);
                    sign_r <= a_r[7] ^ b_r[7];
                end
                SUB: begin
                    d_r <= {1'b0, log_a} - {1'b0, log_b};
                end
                ANTI: begin
                    Q   <= q_calc;
                    dbz <= dbz_calc;
                    sat <= sat_calc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_log_divider.sv
// Directed bench for approx_log_divider: hand-computed quotients, handshakes,
// back-pressure and mid-operation reset; a second instance covers wrapping overflow.
`timescale 1ns/1ps

module tb_approx_log_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, w_in_ready;
    logic [7:0]  A, B;
    logic        out_valid, w_out_valid;
    logic        out_ready;
    logic [15:0] Q, wQ;
    logic        dbz, w_dbz;
    logic        sat, w_sat;

    int tests    = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    approx_log_divider #(.SAT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .dbz(dbz), .sat(sat)
    );

    approx_log_divider #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .A(A), .B(B), .out_valid(w_out_valid), .out_ready(out_ready),
        .Q(wQ), .dbz(w_dbz), .sat(w_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen,
    // with res = number of posedges after the accept edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int res);
        int guard;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A        = 8'h55;
        B        = 8'h00;
        res      = 0;
        while (!out_valid && res < 20) begin
            @(negedge clk);
            res++;
        end
    endtask

    task automatic checkOutput(input string tag, input int l, input logic [15:0] eq,
                               input logic edbz, input logic esat,
                               input logic [15:0] ewq, input logic ewsat);
        check({tag, "_latency"}, l, 3);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_q"}, Q, eq);
        check({tag, "_dbz"}, dbz, edbz);
        check({tag, "_sat"}, sat, esat);
        check({tag, "_wrap_valid"}, w_out_valid, 1'b1);
        check({tag, "_wrap_q"}, wQ, ewq);
        check({tag, "_wrap_dbz"}, w_dbz, edbz);
        check({tag, "_wrap_sat"}, w_sat, ewsat);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 1'b0);
        check({tag, "_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 8'd0;
        B         = 8'd0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_q", Q, 16'h0000);
        check("rst_dbz", dbz, 1'b0);
        check("rst_sat", sat, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(8'd100, 8'd5, lat);
        checkOutput("100_5", lat, 16'h1500, 1'b0, 1'b0, 16'h1500, 1'b0);
        applyStimulus(8'd7, 8'd64, lat);
        checkOutput("7_64", lat, 16'h001C, 1'b0, 1'b0, 16'h001C, 1'b0);
        applyStimulus(8'd9, 8'd9, lat);
        checkOutput("9_9", lat, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0);
        applyStimulus(8'hF7, 8'd9, lat);
        checkOutput("m9_9", lat, 16'hFF00, 1'b0, 1'b0, 16'hFF00, 1'b0);
        applyStimulus(8'h80, 8'd1, lat);
        checkOutput("m128_1", lat, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b0);
        applyStimulus(8'h80, 8'hFF, lat);
        checkOutput("m128_m1", lat, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b1);
        applyStimulus(8'd1, 8'd127, lat);
        checkOutput("1_127", lat, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0);
        applyStimulus(8'd127, 8'd1, lat);
        checkOutput("127_1", lat, 16'h7F00, 1'b0, 1'b0, 16'h7F00, 1'b0);
        applyStimulus(8'hFF, 8'h80, lat);
        checkOutput("m1_m128", lat, 16'h0002, 1'b0, 1'b0, 16'h0002, 1'b0);
        applyStimulus(8'd5, 8'd0, lat);
        checkOutput("5_0", lat, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 1'b0);
        applyStimulus(8'hFB, 8'd0, lat);
        checkOutput("m5_0", lat, 16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0);
        applyStimulus(8'd0, 8'd0, lat);
        checkOutput("0_0", lat, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(8'd0, 8'hFD, lat);
        checkOutput("0_m3", lat, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Back-pressure: result must hold while new operands are offered.
        out_ready = 1'b0;
        applyStimulus(8'd100, 8'd5, lat);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            A        = 8'(i * 13 + 1);
            B        = 8'(i + 2);
            in_valid = 1'b1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_q", Q, 16'h1500);
            check("bp_in_ready", in_ready, 1'b0);
        end
        A         = 8'd9;
        B         = 8'd9;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        applyStimulus(8'd9, 8'd9, lat);
        checkOutput("bp_next", lat, 16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0);

        // Reset while the divider sits in SUB.
        A        = 8'd100;
        B        = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_q", Q, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_output", out_valid, 1'b0);
        end
        applyStimulus(8'hF7, 8'd9, lat);
        checkOutput("after_rst", lat, 16'hFF00, 1'b0, 1'b0, 16'hFF00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
